// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// All outputs are registered; the line idles high.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (i_Tx_DV) begin
          shreg_d  = i_Tx_Byte;
          active_d = 1'b1;
          serial_d = 1'b0;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = shreg_q[0];
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          // shift so the next bit to send always sits in bit 1
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: cycle-exact frame model at 4 clocks/bit
// plus a mid-bit sampling receiver at the default 434 clocks/bit.
module tb_uart_tx_core;

  localparam int C4 = 4;
  localparam int CD = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv4 = 1'b0;
  logic [7:0] byte4 = '0;
  logic       act4, ser4, done4;
  logic       dvd = 1'b0;
  logic [7:0] byted = '0;
  logic       actd, serd, doned;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.CLKS_PER_BIT(C4)) u4 (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Tx_DV(dv4), .i_Tx_Byte(byte4),
    .o_Tx_Active(act4), .o_Tx_Serial(ser4),
    .o_Tx_Done(done4)
  );

  uart_tx_core ud (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Tx_DV(dvd), .i_Tx_Byte(byted),
    .o_Tx_Active(actd), .o_Tx_Serial(serd),
    .o_Tx_Done(doned)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [7:0] b,
                                    input int s);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    return fr[s];
  endfunction

  // Caller has raised dv4 with byte b; the next edge accepts.
  // inj >= 0 raises a 0xFF request inside the frame.
  task automatic frame4(input logic [7:0] b, input int inj,
                        input bit chain,
                        input logic [7:0] nb);
    for (int k = 0; k < 10 * C4; k++) begin
      @(posedge clk); #1;
      if (k == 0) dv4 = 1'b0;
      if (k == inj) begin
        dv4 = 1'b1; byte4 = 8'hFF;
      end
      if (k == inj + 1) dv4 = 1'b0;
      chk("ser4", 32'(ser4), 32'(slot_bit(b, k / C4)));
      chk("act4", 32'(act4), 32'd1);
      chk("done4_early", 32'(done4), 32'd0);
    end
    @(posedge clk); #1;
    chk("done4", 32'(done4), 32'd1);
    chk("act4_end", 32'(act4), 32'd0);
    chk("ser4_end", 32'(ser4), 32'd1);
    if (chain) begin
      dv4 = 1'b1; byte4 = nb;
    end else begin
      @(posedge clk); #1;
      chk("done4_pulse", 32'(done4), 32'd0);
      chk("ser4_idle", 32'(ser4), 32'd1);
    end
  endtask

  task automatic framed(input logic [7:0] b);
    logic [9:0] rx;
    int first_done;
    rx = '0;
    first_done = -1;
    dvd = 1'b1; byted = b;
    @(posedge clk); #1;
    dvd = 1'b0; byted = ~b;
    for (int k = 1; k <= 10 * CD; k++) begin
      @(posedge clk); #1;
      if ((k % CD) == CD / 2) rx[k / CD] = serd;
      if (doned && first_done < 0) first_done = k;
    end
    chk("rx_start", 32'(rx[0]), 32'd0);
    chk("rx_byte", 32'(rx[8:1]), 32'(b));
    chk("rx_stop", 32'(rx[9]), 32'd1);
    chk("done_lat", 32'(first_done), 32'(10 * CD));
    chk("actd_end", 32'(actd), 32'd0);
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    #13;
    chk("rst_ser", 32'(ser4), 32'd1);
    chk("rst_act", 32'(act4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    dv4 = 1'b1; byte4 = 8'hA5;
    frame4(8'hA5, -1, 1'b0, 8'h00);

    dv4 = 1'b1; byte4 = 8'h00;
    frame4(8'h00, 10, 1'b0, 8'h00);
    for (int k = 0; k < 2 * C4; k++) begin
      @(posedge clk); #1;
      chk("no_2nd_act", 32'(act4), 32'd0);
      chk("no_2nd_done", 32'(done4), 32'd0);
    end

    r0 = 8'($urandom);
    dv4 = 1'b1; byte4 = 8'h5A;
    frame4(8'h5A, -1, 1'b1, 8'h3C);
    frame4(8'h3C, -1, 1'b1, r0);
    frame4(r0, -1, 1'b0, 8'h00);

    for (int n = 0; n < 4; n++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      dv4 = 1'b1; byte4 = r1;
      frame4(r1, int'($urandom_range(0, 30)), 1'b0, 8'h00);
      dv4 = 1'b1; byte4 = r2;
      frame4(r2, -1, 1'b0, 8'h00);
    end

    // abort during data bit 3 (slot 4), asynchronously
    dv4 = 1'b1; byte4 = 8'h00;
    @(posedge clk); #1;
    dv4 = 1'b0;
    repeat (4 * C4 + 1) @(posedge clk);
    #2;
    chk("pre_rst_act", 32'(act4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ser", 32'(ser4), 32'd1);
    chk("arst_act", 32'(act4), 32'd0);
    chk("arst_done", 32'(done4), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_hold_done", 32'(done4), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12 * C4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_done", 32'(done4), 32'd0);
      chk("post_rst_ser", 32'(ser4), 32'd1);
    end
    r1 = 8'($urandom);
    dv4 = 1'b1; byte4 = r1;
    frame4(r1, -1, 1'b0, 8'h00);

    framed(8'h41);
    framed(8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
